hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage WISC-SP20 core.
- Decides each cycle whether PC and IF/ID advance or hold, and whether IF/ID or ID/EX loads a NOP. ID/EX receives the NOP through its stall_decode input.
- Detects load-use hazards and inserts a parameterised number of bubbles. Flushes on taken branch/jump, freezes the whole pipe on data-memory stall, and holds the core after halt retires.
- Keeps a saturating stall-cycle counter for performance debug.

---
 rtl/hazard_ctrl.sv | 66 ++++++
 tb/tb_hazard_ctrl.sv | 117 +++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline advance/hold/flush/freeze sequencing with load-use bubbles and a saturating stall counter
module hazard_ctrl #(
  parameter int LU_BUBBLES = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       id_rs,
  input  logic [2:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             idex_mem_read,
  input  logic             idex_reg_write,
  input  logic [2:0]       idex_write_sel,
  input  logic             branch_taken,
  input  logic             imem_stall,
  input  logic             dmem_stall,
  input  logic             halt_wb,
  output logic             pc_write_en,
  output logic             if_id_write_en,
  output logic             flush_if_id,
  output logic             stall_decode,
  output logic             freeze_pipe,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count
);
  typedef enum logic [1:0] {RUN, LU_STALL, HALTED} state_t;
  state_t state_q, state_d;
  logic [1:0] bub_q, bub_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic lu, halt, frz, br, lus, ims, stall_any;
  always_comb begin
    lu = idex_mem_read & idex_reg_write &
         ((id_uses_rs & (id_rs == idex_write_sel)) | (id_uses_rt & (id_rt == idex_write_sel)));
    halt = (state_q == HALTED) | halt_wb;
    frz = !halt & dmem_stall;
    br = !halt & !dmem_stall & branch_taken;
    lus = !halt & !dmem_stall & !branch_taken & (lu | (state_q == LU_STALL));
    ims = !halt & !dmem_stall & !branch_taken & !lu & (state_q != LU_STALL) & imem_stall;
    pc_write_en = !(halt | frz | lus | ims);
    if_id_write_en = !(halt | frz | lus);
    flush_if_id = br | ims;
    stall_decode = halt | br | lus;
    freeze_pipe = frz;
    halted = halt;
    stall_any = !pc_write_en | flush_if_id | stall_decode | freeze_pipe;
    state_d = halt ? HALTED : (frz || !lus) ? (br ? RUN : state_q) :
              (state_q == LU_STALL) ? ((bub_q == 2'd1) ? RUN : LU_STALL) :
              ((LU_BUBBLES > 1) ? LU_STALL : RUN);
    bub_d = (halt || frz) ? bub_q : br ? 2'd0 : !lus ? bub_q :
            (state_q == LU_STALL) ? bub_q - 2'd1 : 2'(LU_BUBBLES - 1);
    cnt_d = (stall_any && state_q != HALTED && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
    stall_count = cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      bub_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      bub_q <= bub_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench comparing three parameterisations against a priority-rule reference model
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst, urs, urt, mr, rw, br, im, dm, hw;
  logic [2:0] rs, rt, ws;
  logic [5:0] o [3];
  logic [15:0] cnt [3];
  logic [2:0][21:0] sb [$];
  int left [3];
  bit hm [3];
  int mc [3];
  bit known;
  int n_chk, n_fail;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : gen_dut
    localparam int CW = (g == 1) ? 4 : 16;
    logic [CW-1:0] sc;
    hazard_ctrl #(.LU_BUBBLES(g + 1), .CNT_W(CW)) u_dut (
      .clk(clk), .rst(rst), .id_rs(rs), .id_rt(rt), .id_uses_rs(urs), .id_uses_rt(urt),
      .idex_mem_read(mr), .idex_reg_write(rw), .idex_write_sel(ws), .branch_taken(br),
      .imem_stall(im), .dmem_stall(dm), .halt_wb(hw),
      .pc_write_en(o[g][5]), .if_id_write_en(o[g][4]), .flush_if_id(o[g][3]),
      .stall_decode(o[g][2]), .freeze_pipe(o[g][1]), .halted(o[g][0]), .stall_count(sc)
    );
    assign cnt[g] = 16'(sc);
  end
  task automatic model(input int i, output logic [21:0] e);
    bit h, lu, pc, ifw, fl, sd, fz;
    int mx;
    mx = (i == 1) ? 15 : 65535;
    lu = mr && rw && ((urs && rs == ws) || (urt && rt == ws));
    h = hm[i] || hw;
    pc = 1; ifw = 1; fl = 0; sd = 0; fz = 0;
    if (h) begin pc = 0; ifw = 0; sd = 1; end
    else if (dm) begin pc = 0; ifw = 0; fz = 1; end
    else if (br) begin fl = 1; sd = 1; left[i] = 0; end
    else if (lu || left[i] > 0) begin
      pc = 0; ifw = 0; sd = 1;
      left[i] = (left[i] > 0) ? left[i] - 1 : i;
    end
    else if (im) begin pc = 0; fl = 1; end
    e = {pc, ifw, fl, sd, fz, h, 16'(mc[i])};
    if (rst) begin
      hm[i] = 0; left[i] = 0; mc[i] = 0;
    end else begin
      if ((!pc || fl || sd || fz) && !hm[i] && mc[i] < mx) mc[i]++;
      if (h) hm[i] = 1;
    end
  endtask
  task automatic tick();
    logic [2:0][21:0] e;
    for (int i = 0; i < 3; i++) model(i, e[i]);
    if (known) sb.push_back(e);
    if (rst) known = 1;
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    {rst, urs, urt, mr, rw, br, im, dm, hw} = '0;
    rs = 0; rt = 0; ws = 0;
  endtask
  task automatic haz();
    mr = 1; rw = 1; ws = 3; rs = 3; urs = 1;
  endtask
  task automatic rnd();
    rst = ($urandom_range(0, 99) == 0);
    hw = ($urandom_range(0, 149) == 0);
    mr = 1'($urandom); rw = 1'($urandom); urs = 1'($urandom); urt = 1'($urandom);
    rs = 3'($urandom_range(0, 3)); rt = 3'($urandom_range(0, 3)); ws = 3'($urandom_range(0, 3));
    br = ($urandom_range(0, 7) == 0);
    dm = ($urandom_range(0, 7) == 0);
    im = ($urandom_range(0, 5) == 0);
  endtask
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      logic [2:0][21:0] e;
      e = sb.pop_front();
      for (int i = 0; i < 3; i++) begin
        n_chk++;
        if ({o[i], cnt[i]} !== e[i]) begin
          n_fail++;
          $display("FAIL lub%0d t=%0t outs/count got %b/%0d want %b/%0d",
                   i + 1, $time, o[i], cnt[i], e[i][21:16], e[i][15:0]);
        end
      end
    end
  end
  initial begin
    n_chk = 0; n_fail = 0; known = 0;
    clr();
    rst = 1;
    repeat (2) tick();
    rst = 0;
    haz(); tick(); clr(); repeat (4) tick();
    rst = 1; tick(); rst = 0;
    haz(); tick(); clr(); tick();
    dm = 1; repeat (4) tick(); dm = 0; repeat (4) tick();
    haz(); br = 1; tick(); clr(); repeat (3) tick();
    haz(); tick(); clr(); br = 1; tick(); br = 0; repeat (3) tick();
    haz(); tick(); ws = 5; tick(); clr(); repeat (3) tick();
    im = 1; repeat (2) tick(); im = 0; tick();
    hw = 1; tick(); hw = 0;
    repeat (10) begin rnd(); rst = 0; tick(); end
    clr(); rst = 1; tick(); rst = 0; repeat (2) tick();
    repeat (3000) begin rnd(); tick(); end
    clr(); rst = 1; tick(); rst = 0; tick();
    @(negedge clk);
    #1;
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain queue got %0d entries want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
